// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults for the instruction-fetch slice.
//   XLEN_DEF / ILEN_DEF : default PC and instruction widths
//   PC_STEP_DEF         : sequential PC increment (word-addressed ROM)
//   DEPTH_DEF           : default prefetch queue depth
//   RESET_PC_DEF        : fetch address after reset
//   NOP_INSTR           : encoding decode inserts for bubbles
package fetch_pkg;
   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned ILEN_DEF     = 32;
   localparam int unsigned PC_STEP_DEF  = 1;
   localparam int unsigned DEPTH_DEF    = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH x WIDTH FIFO holding {pc, instr} entries.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empties the FIFO (overrides push and pop)
//   push/data  : write push_data at the tail
//   pop        : drop the head entry (caller guarantees non-empty)
//   head       : current head entry (undefined when count == 0)
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_buffered.sv
// fetch_buffered: instruction fetch with a DEPTH-entry prefetch queue.
// Issues reads to a one-cycle-latency ROM, queues {pc, instr} responses
// and hands them to decode over valid/ready; redirect flushes and restarts.
//   clk, rst                : clock, asynchronous active-high reset
//   redirect/redirect_target: taken branch/jump and its target PC
//   rom_en/rom_addr         : ROM read request and address
//   rom_data                : ROM data, valid the cycle after rom_en
//   instr_valid/instr_ready : decode handshake for the queue head
//   instr/instr_pc          : head instruction and its PC (0 when invalid)
module fetch_buffered
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter int unsigned     ILEN     = ILEN_DEF,
   parameter int unsigned     PC_STEP  = PC_STEP_DEF,
   parameter int unsigned     DEPTH    = DEPTH_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   output logic            rom_en,
   output logic [XLEN-1:0] rom_addr,
   input  logic [ILEN-1:0] rom_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [XLEN-1:0]      fetch_pc;
   logic                 inflight;
   logic [XLEN-1:0]      inflight_pc;
   logic [CW-1:0]        count;
   logic [XLEN+ILEN-1:0] head;
   logic                 deq;
   logic                 push;
   logic [CW:0]          pending;

   fetch_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data ({inflight_pc, rom_data}),
      .pop       (deq),
      .head      (head),
      .count     (count)
   );

   assign instr_valid = (count != '0) && !redirect;
   assign deq         = instr_valid && instr_ready;
   assign push        = inflight && !redirect;

   // Credit check: entries held after this cycle's dequeue plus the word
   // already in flight must leave room for the word issued now.
   always_comb begin
      pending = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
      rom_en  = !rst && !redirect && (pending < (CW+1)'(DEPTH));
   end

   assign rom_addr = fetch_pc;
   assign instr    = instr_valid ? head[ILEN-1:0] : '0;
   assign instr_pc = instr_valid ? head[XLEN+ILEN-1:ILEN] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_target;
         inflight <= 1'b0;
      end else if (rom_en) begin
         fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         inflight <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_buffered.sv
// tb_fetch_buffered: self-checking bench for fetch_buffered.
// ROM word at address a is a + 0x100. A cycle-accurate vector table covers
// reset release and a 12-cycle stall; a PC scoreboard covers streams after
// reset, redirect and back-to-back redirect; a second instance starts near
// the top of the address space to exercise PC wrap.
module tb_fetch_buffered;
   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        rom_en;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   logic        redirect_w;
   logic [31:0] target_w;
   logic        rom_en_w;
   logic [31:0] rom_addr_w;
   logic [31:0] rom_data_w;
   logic        instr_valid_w;
   logic        ready_w;
   logic [31:0] instr_w;
   logic [31:0] instr_pc_w;

   int checks = 0;
   int errors = 0;

   fetch_buffered dut (
      .clk             (clk),
      .rst             (rst),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .rom_en          (rom_en),
      .rom_addr        (rom_addr),
      .rom_data        (rom_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc)
   );

   fetch_buffered #(.RESET_PC(32'hFFFF_FFFE)) dut_w (
      .clk             (clk),
      .rst             (rst),
      .redirect        (redirect_w),
      .redirect_target (target_w),
      .rom_en          (rom_en_w),
      .rom_addr        (rom_addr_w),
      .rom_data        (rom_data_w),
      .instr_valid     (instr_valid_w),
      .instr_ready     (ready_w),
      .instr           (instr_w),
      .instr_pc        (instr_pc_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous ROM models, one-cycle latency.
   always @(posedge clk) if (rom_en)   rom_data   <= rom_addr + 32'h100;
   always @(posedge clk) if (rom_en_w) rom_data_w <= rom_addr_w + 32'h100;

   typedef struct {
      logic        ready;
      logic        exp_en;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t        tbl [18];
   logic [31:0] sb_q [$];
   logic        sb_on = 1'b0;
   int          sb_pops = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic sb_fill(input logic [31:0] base, input int n);
      sb_q.delete();
      for (int i = 0; i < n; i++) sb_q.push_back(base + i);
      sb_pops = 0;
   endtask

   // Let inputs settle, then compare any accepted head against the scoreboard.
   task automatic settle();
      logic [31:0] exp;
      #1;
      if (sb_on && instr_valid && instr_ready) begin
         sb_pops++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra actual_pc=%h expected=none", instr_pc);
         end else begin
            exp = sb_q.pop_front();
            if (instr_pc !== exp || instr !== exp + 32'h100) begin
               errors++;
               $display("FAIL sb_stream actual_pc=%h actual_instr=%h expected_pc=%h expected_instr=%h",
                        instr_pc, instr, exp, exp + 32'h100);
            end
         end
      end
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         adv();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      logic [31:0] wpc;
      logic        wv;

      // ready low for cycles 0..11, head pc 0 held; released at cycle 12.
      tbl[0]  = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0};
      tbl[1]  = '{1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
      tbl[2]  = '{1'b0, 1'b1, 32'd2, 1'b1, 32'd0};
      tbl[3]  = '{1'b0, 1'b1, 32'd3, 1'b1, 32'd0};
      for (int i = 4; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 32'd4, 1'b1, 32'd0};
      tbl[12] = '{1'b1, 1'b1, 32'd4, 1'b1, 32'd0};
      tbl[13] = '{1'b1, 1'b1, 32'd5, 1'b1, 32'd1};
      tbl[14] = '{1'b1, 1'b1, 32'd6, 1'b1, 32'd2};
      tbl[15] = '{1'b1, 1'b1, 32'd7, 1'b1, 32'd3};
      tbl[16] = '{1'b1, 1'b1, 32'd8, 1'b1, 32'd4};
      tbl[17] = '{1'b1, 1'b1, 32'd9, 1'b1, 32'd5};

      rst = 1'b1; redirect = 1'b0; redirect_target = '0; instr_ready = 1'b0;
      redirect_w = 1'b0; target_w = '0; ready_w = 1'b1;
      adv();
      settle();
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 32'h0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_w_rom_addr", rom_addr_w, 32'hFFFF_FFFE);
      adv();

      // Vector table (main DUT) alongside the wrap instance with ready high.
      rst = 1'b0;
      for (int i = 0; i < 18; i++) begin
         instr_ready = tbl[i].ready;
         settle();
         chk($sformatf("tbl%0d_rom_en", i), rom_en, tbl[i].exp_en);
         chk($sformatf("tbl%0d_rom_addr", i), rom_addr, tbl[i].exp_addr);
         chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].exp_valid);
         chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0);
         chk($sformatf("tbl%0d_instr", i), instr,
             tbl[i].exp_valid ? tbl[i].exp_pc + 32'h100 : 32'h0);
         if (i < 6) begin
            wv  = (i >= 2);
            wpc = wv ? 32'hFFFF_FFFE + 32'(i - 2) : 32'h0;
            chk($sformatf("wrap%0d_addr", i), rom_addr_w, 32'hFFFF_FFFE + 32'(i));
            chk($sformatf("wrap%0d_valid", i), instr_valid_w, wv);
            chk($sformatf("wrap%0d_pc", i), instr_pc_w, wpc);
            chk($sformatf("wrap%0d_instr", i), instr_w, wv ? wpc + 32'h100 : 32'h0);
         end
         adv();
      end

      // Fill the queue, then reset mid-stream.
      instr_ready = 1'b0;
      k = 0;
      settle();
      while (rom_en && k < 20) begin
         adv();
         settle();
         k++;
      end
      chk("fill_stall_rom_en", rom_en, 0);
      adv();
      settle();
      chk("full_rom_en", rom_en, 0);
      chk("full_valid", instr_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", instr_valid, 0);
      chk("async_rst_rom_en", rom_en, 0);
      chk("async_rst_rom_addr", rom_addr, 32'h0);
      chk("async_rst_instr", instr, 0);
      adv();
      adv();

      // Restart with ready high: identical to the first stream, 1 per cycle.
      rst = 1'b0;
      instr_ready = 1'b1;
      sb_fill(32'h0, 64);
      sb_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         settle();
         if (i < 2)  chk($sformatf("restart_valid%0d", i), instr_valid, 0);
         if (i == 2) chk("restart_valid2", instr_valid, 1);
         adv();
      end
      sb_on = 1'b0;
      chk("restart_throughput", sb_pops, 18);

      // Redirect while 3 entries queued and 1 in flight.
      rst = 1'b1;
      adv();
      rst = 1'b0;
      instr_ready = 1'b0;
      run(4);
      redirect = 1'b1;
      redirect_target = 32'h40;
      settle();
      chk("redir_valid", instr_valid, 0);
      chk("redir_rom_en", rom_en, 0);
      adv();
      redirect = 1'b0;
      settle();
      chk("redir_r1_rom_en", rom_en, 1);
      chk("redir_r1_rom_addr", rom_addr, 32'h40);
      chk("redir_r1_valid", instr_valid, 0);
      adv();
      settle();
      chk("redir_r2_valid", instr_valid, 0);
      adv();
      instr_ready = 1'b1;
      sb_fill(32'h40, 64);
      sb_on = 1'b1;
      settle();
      chk("redir_r3_valid", instr_valid, 1);
      chk("redir_r3_pc", instr_pc, 32'h40);
      adv();
      run(15);
      sb_on = 1'b0;
      chk("redir_throughput", sb_pops, 16);

      // Back-to-back redirects: only the 0x80 stream may emerge.
      redirect = 1'b1;
      redirect_target = 32'h40;
      settle();
      chk("b2b_first_valid", instr_valid, 0);
      adv();
      redirect_target = 32'h80;
      settle();
      chk("b2b_second_valid", instr_valid, 0);
      adv();
      redirect = 1'b0;
      sb_fill(32'h80, 64);
      sb_on = 1'b1;
      settle();
      chk("b2b_rom_addr", rom_addr, 32'h80);
      adv();
      run(11);
      sb_on = 1'b0;
      chk("b2b_throughput", sb_pops, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
